glb_proc_packet_initiator: RTL and testbench



---
 rtl/global_buffer_param.sv | 6 +
 rtl/global_buffer_pkg.sv | 32 +++
 rtl/glb_proc_packet_initiator_if.sv | 34 +++
 rtl/glb_proc_rd_timer.sv | 26 ++
 rtl/glb_proc_packet_initiator.sv | 141 ++++++++++++++
 tb/tb_glb_proc_packet_initiator.sv | 211 +++++++++++++++++++++
 6 files changed

// File: rtl/global_buffer_param.sv
// Width constants shared by the global buffer tile and its processor-side endpoint.
package global_buffer_param;
   localparam int BANK_DATA_WIDTH = 64;
   localparam int BANK_STRB_WIDTH = BANK_DATA_WIDTH / 8;
   localparam int GLB_ADDR_WIDTH  = 19;
endpackage

// File: rtl/global_buffer_pkg.sv
// Packet chain field layouts and the processor read FSM state encoding.
package global_buffer_pkg;
   import global_buffer_param::*;

   typedef struct packed {
      logic                       wr_en;
      logic [BANK_STRB_WIDTH-1:0] wr_strb;
      logic [GLB_ADDR_WIDTH-1:0]  wr_addr;
      logic [BANK_DATA_WIDTH-1:0] wr_data;
   } wr_packet_t;

   typedef struct packed {
      logic                      rd_en;
      logic [GLB_ADDR_WIDTH-1:0] rd_addr;
   } rdrq_packet_t;

   typedef struct packed {
      logic [BANK_DATA_WIDTH-1:0] rd_data;
      logic                       rd_data_valid;
   } rdrs_packet_t;

   typedef struct packed {
      wr_packet_t   wr;
      rdrq_packet_t rdrq;
      rdrs_packet_t rdrs;
   } packet_t;

   typedef enum logic {
      RD_IDLE = 1'b0,
      RD_WAIT = 1'b1
   } proc_rd_state_e;
endpackage

// File: rtl/glb_proc_packet_initiator_if.sv
// Processor request/response signals plus the east-side packet chain pair of the initiator.
interface glb_proc_packet_initiator_if;
   import global_buffer_param::*;
   import global_buffer_pkg::*;

   logic                       proc_wr_en;
   logic [BANK_STRB_WIDTH-1:0] proc_wr_strb;
   logic [GLB_ADDR_WIDTH-1:0]  proc_wr_addr;
   logic [BANK_DATA_WIDTH-1:0] proc_wr_data;
   logic                       proc_rd_en;
   logic [GLB_ADDR_WIDTH-1:0]  proc_rd_addr;
   logic                       proc_rd_ready;
   logic [BANK_DATA_WIDTH-1:0] proc_rd_data;
   logic                       proc_rd_data_valid;
   logic                       proc_rd_err;
   logic                       proc_rd_stray;
   packet_t                    packet_esto;
   packet_t                    packet_esti;

   // slave: the initiator itself; master: the processor / chain model driving it
   modport slave (
      input  proc_wr_en, proc_wr_strb, proc_wr_addr, proc_wr_data,
      input  proc_rd_en, proc_rd_addr, packet_esti,
      output proc_rd_ready, proc_rd_data, proc_rd_data_valid, proc_rd_err,
      output proc_rd_stray, packet_esto
   );

   modport master (
      output proc_wr_en, proc_wr_strb, proc_wr_addr, proc_wr_data,
      output proc_rd_en, proc_rd_addr, packet_esti,
      input  proc_rd_ready, proc_rd_data, proc_rd_data_valid, proc_rd_err,
      input  proc_rd_stray, packet_esto
   );
endinterface

// File: rtl/glb_proc_rd_timer.sv
// Saturating wait-cycle counter: clr restarts at 0, en counts up, expire flags LIMIT-1 while enabled.
// Registered count, combinational expire; no backpressure.
module glb_proc_rd_timer #(
   parameter int LIMIT = 1024
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic expire
);
   localparam int CNT_W = (LIMIT > 2) ? $clog2(LIMIT) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LIMIT - 1);

   logic [CNT_W-1:0] count_q;

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         count_q <= '0;
      end else if (en && (count_q != CNT_MAX)) begin
         count_q <= count_q + 1'b1;
      end
   end

   assign expire = en && (count_q == CNT_MAX);
endmodule

// File: rtl/glb_proc_packet_initiator.sv
// Processor endpoint of the packet chain: writes/reads -> packet_esto (1 cycle), responses -> proc (1 cycle).
// Writes never stall; one read outstanding, proc_rd_ready low while waiting. Optional timeout: GLB_PROC_RD_TIMEOUT_EN.
module glb_proc_packet_initiator
   import global_buffer_param::*;
   import global_buffer_pkg::*;
#(
   parameter int RD_TIMEOUT = 1024
) (
   input logic                         clk,
   input logic                         reset,
   glb_proc_packet_initiator_if.slave  bus
);
   proc_rd_state_e state_q, state_d;

   wr_packet_t                 wr_d;
   rdrq_packet_t               rdrq_d;
   packet_t                    esto_q;
   logic                       rd_issue;
   logic                       rsp_take;
   logic                       rsp_stray;
   logic                       rd_expire;
   logic                       timer_expire;
   logic                       rsp_vld;
   logic [BANK_DATA_WIDTH-1:0] rd_data_q;
   logic                       rd_vld_q;
   logic                       rd_stray_q;
   logic                       unused_esti;

   assign rsp_vld     = bus.packet_esti.rdrs.rd_data_valid;
   assign unused_esti = ^{bus.packet_esti.wr, bus.packet_esti.rdrq};

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= RD_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // A response in the timeout cycle takes priority over the forced error.
   always_comb begin
      state_d   = state_q;
      rd_issue  = 1'b0;
      rsp_take  = 1'b0;
      rsp_stray = 1'b0;
      rd_expire = 1'b0;
      case (state_q)
         RD_IDLE: begin
            rsp_stray = rsp_vld;
            if (bus.proc_rd_en) begin
               rd_issue = 1'b1;
               state_d  = RD_WAIT;
            end
         end
         RD_WAIT: begin
            if (rsp_vld) begin
               rsp_take = 1'b1;
               state_d  = RD_IDLE;
            end else if (timer_expire) begin
               rd_expire = 1'b1;
               state_d   = RD_IDLE;
            end
         end
         default: state_d = RD_IDLE;
      endcase
   end

   always_comb begin
      wr_d   = '0;
      rdrq_d = '0;
      if (bus.proc_wr_en) begin
         wr_d.wr_en   = 1'b1;
         wr_d.wr_strb = bus.proc_wr_strb;
         wr_d.wr_addr = bus.proc_wr_addr;
         wr_d.wr_data = bus.proc_wr_data;
      end
      if (rd_issue) begin
         rdrq_d.rd_en   = 1'b1;
         rdrq_d.rd_addr = bus.proc_rd_addr;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         esto_q     <= '0;
         rd_data_q  <= '0;
         rd_vld_q   <= 1'b0;
         rd_stray_q <= 1'b0;
      end else begin
         esto_q.wr   <= wr_d;
         esto_q.rdrq <= rdrq_d;
         esto_q.rdrs <= '0;
         rd_vld_q    <= rsp_take | rd_expire;
         rd_stray_q  <= rsp_stray;
         if (rsp_take) begin
            rd_data_q <= bus.packet_esti.rdrs.rd_data;
         end else if (rd_expire) begin
            rd_data_q <= '0;
         end
      end
   end

`ifdef GLB_PROC_RD_TIMEOUT_EN
   logic rd_err_q;
   logic rd_waiting;

   assign rd_waiting = (state_q == RD_WAIT);

   glb_proc_rd_timer #(
      .LIMIT (RD_TIMEOUT)
   ) u_rd_timer (
      .clk    (clk),
      .reset  (reset),
      .clr    (rd_issue),
      .en     (rd_waiting),
      .expire (timer_expire)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_err_q <= 1'b0;
      end else begin
         rd_err_q <= rd_expire;
      end
   end

   assign bus.proc_rd_err = rd_err_q;
`else
   logic unused_rd_timeout;

   assign unused_rd_timeout = (RD_TIMEOUT != 0);
   assign timer_expire      = 1'b0;
   assign bus.proc_rd_err   = 1'b0;
`endif

   assign bus.proc_rd_ready      = (state_q == RD_IDLE);
   assign bus.proc_rd_data       = rd_data_q;
   assign bus.proc_rd_data_valid = rd_vld_q;
   assign bus.proc_rd_stray      = rd_stray_q;
   assign bus.packet_esto        = esto_q;
endmodule

// File: tb/tb_glb_proc_packet_initiator.sv
// Directed + random bench for glb_proc_packet_initiator against a transaction-level read/write model.
module tb_glb_proc_packet_initiator;
   import global_buffer_param::*;
   import global_buffer_pkg::*;

   localparam int RD_TIMEOUT = 8;
`ifdef GLB_PROC_RD_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   int   n_cmp = 0;
   int   n_bad = 0;

   // model: is a read outstanding, and for how many cycles (1 = first waiting cycle)
   bit                         busy;
   int                         age;
   logic [BANK_DATA_WIDTH-1:0] m_data;

   glb_proc_packet_initiator_if intf ();

   glb_proc_packet_initiator #(
      .RD_TIMEOUT (RD_TIMEOUT)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (intf.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_inputs();
      intf.proc_wr_en   = 1'b0;
      intf.proc_wr_strb = '0;
      intf.proc_wr_addr = '0;
      intf.proc_wr_data = '0;
      intf.proc_rd_en   = 1'b0;
      intf.proc_rd_addr = '0;
      intf.packet_esti  = '0;
   endtask

   task automatic set_rsp(input logic vld, input logic [BANK_DATA_WIDTH-1:0] data);
      intf.packet_esti                    = '0;
      intf.packet_esti.rdrs.rd_data_valid = vld;
      intf.packet_esti.rdrs.rd_data       = data;
   endtask

   // One clock: check ready now, predict what the inputs of this cycle produce, check after the edge.
   task automatic cycle();
      packet_t e_pkt;
      logic    e_vld, e_err, e_stray;
      chk("rd_ready", 192'(intf.proc_rd_ready), 192'(!busy));
      e_pkt   = '0;
      e_vld   = 1'b0;
      e_err   = 1'b0;
      e_stray = 1'b0;
      if (reset) begin
         busy   = 1'b0;
         m_data = '0;
      end else begin
         if (intf.proc_wr_en) begin
            e_pkt.wr.wr_en   = 1'b1;
            e_pkt.wr.wr_strb = intf.proc_wr_strb;
            e_pkt.wr.wr_addr = intf.proc_wr_addr;
            e_pkt.wr.wr_data = intf.proc_wr_data;
         end
         if (busy) begin
            if (intf.packet_esti.rdrs.rd_data_valid) begin
               e_vld  = 1'b1;
               m_data = intf.packet_esti.rdrs.rd_data;
               busy   = 1'b0;
            end else if (TO_EN && age == RD_TIMEOUT) begin
               e_vld  = 1'b1;
               e_err  = 1'b1;
               m_data = '0;
               busy   = 1'b0;
            end else begin
               age++;
            end
         end else begin
            e_stray = intf.packet_esti.rdrs.rd_data_valid;
            if (intf.proc_rd_en) begin
               e_pkt.rdrq.rd_en   = 1'b1;
               e_pkt.rdrq.rd_addr = intf.proc_rd_addr;
               busy = 1'b1;
               age  = 1;
            end
         end
      end
      @(posedge clk);
      #1;
      chk("packet_esto",   192'(intf.packet_esto),        192'(e_pkt));
      chk("rd_data_valid", 192'(intf.proc_rd_data_valid), 192'(e_vld));
      chk("rd_err",        192'(intf.proc_rd_err),        192'(e_err));
      chk("rd_stray",      192'(intf.proc_rd_stray),      192'(e_stray));
      chk("rd_data",       192'(intf.proc_rd_data),       192'(m_data));
   endtask

   initial begin
      clear_inputs();
      reset  = 1'b1;
      busy   = 1'b0;
      age    = 0;
      m_data = '0;
      @(posedge clk);
      #1;
      repeat (2) cycle();
      reset = 1'b0;
      repeat (3) cycle();

      // single full-strobe write, then idle bus
      intf.proc_wr_en   = 1'b1;
      intf.proc_wr_addr = GLB_ADDR_WIDTH'(32'h100);
      intf.proc_wr_data = 64'hDEAD_BEEF;
      intf.proc_wr_strb = '1;
      cycle();
      clear_inputs();
      cycle();

      // read 0x40, response 10 cycles after the request
      intf.proc_rd_en   = 1'b1;
      intf.proc_rd_addr = GLB_ADDR_WIDTH'(32'h40);
      cycle();
      clear_inputs();
      repeat (9) cycle();
      set_rsp(1'b1, 64'h1234);
      cycle();
      clear_inputs();
      cycle();

      // read request held through WAIT; reissues once ready returns
      intf.proc_rd_en   = 1'b1;
      intf.proc_rd_addr = GLB_ADDR_WIDTH'(32'h80);
      repeat (4) cycle();
      set_rsp(1'b1, 64'hA5A5_0000_1111_2222);
      cycle();
      set_rsp(1'b0, '0);
      cycle();
      intf.proc_rd_en = 1'b0;
      cycle();
      set_rsp(1'b1, 64'h77);
      cycle();
      clear_inputs();
      cycle();

      // response while idle, simultaneous write and read
      set_rsp(1'b1, 64'hBAD);
      cycle();
      clear_inputs();
      cycle();
      intf.proc_wr_en   = 1'b1;
      intf.proc_wr_addr = GLB_ADDR_WIDTH'(32'h7_0001);
      intf.proc_wr_data = 64'h0123_4567_89AB_CDEF;
      intf.proc_wr_strb = BANK_STRB_WIDTH'(8'h0F);
      intf.proc_rd_en   = 1'b1;
      intf.proc_rd_addr = GLB_ADDR_WIDTH'(32'h2_0000);
      cycle();
      clear_inputs();

      // long wait: timeout (when enabled), then a late response
      repeat (14) cycle();
      set_rsp(1'b1, 64'hFEED);
      cycle();
      clear_inputs();
      cycle();

      // reset in the middle of a wait, then a response for the abandoned read
      intf.proc_rd_en   = 1'b1;
      intf.proc_rd_addr = GLB_ADDR_WIDTH'(32'h55);
      cycle();
      clear_inputs();
      repeat (3) cycle();
      reset = 1'b1;
      repeat (2) cycle();
      reset = 1'b0;
      set_rsp(1'b1, 64'hC0FFEE);
      cycle();
      clear_inputs();
      cycle();

      // random traffic
      repeat (600) begin
         intf.proc_wr_en   = ($urandom_range(0, 1) == 0);
         intf.proc_wr_strb = BANK_STRB_WIDTH'($urandom);
         intf.proc_wr_addr = GLB_ADDR_WIDTH'($urandom);
         intf.proc_wr_data = {$urandom, $urandom};
         intf.proc_rd_en   = ($urandom_range(0, 2) == 0);
         intf.proc_rd_addr = GLB_ADDR_WIDTH'($urandom);
         set_rsp(($urandom_range(0, 9) == 0), {$urandom, $urandom});
         reset = ($urandom_range(0, 99) == 0);
         cycle();
      end
      reset = 1'b0;
      clear_inputs();
      cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
